// File: rtl/mips_reg_writeback_if.sv
// Producer-to-writeback push bus: one result entry per valid/ready handshake.
interface mips_reg_writeback_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_is_link;

  modport master (output wb_valid, wb_reg, wb_data, wb_is_link, input wb_ready);
  modport slave  (input wb_valid, wb_reg, wb_data, wb_is_link, output wb_ready);
endinterface

// File: rtl/mips_reg_writeback.sv
// In-order write-back queue and pending-write scoreboard; one edge from an empty queue to the strobe.
// wb_ready drops when full or during flush/reset, and drains only while drain_enable is high.
module mips_reg_writeback #(
  parameter int DEPTH     = 4,
  parameter int JAL_WIDTH = 13,
  localparam int OW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_reg_writeback_if.slave   wb,
  input  logic                  drain_enable,
  input  logic                  flush,
  input  logic [4:0]            read_reg_1,
  input  logic [4:0]            read_reg_2,
  output logic                  hazard_1,
  output logic                  hazard_2,
  output logic [4:0]            write_reg,
  output logic [31:0]           write_data,
  output logic                  signal_reg_write,
  output logic                  jal,
  output logic [JAL_WIDTH-1:0]  jal_address,
  output logic [OW-1:0]         occupancy
);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        occ_q, occ_d;
  logic [4:0]           q_reg_q  [DEPTH];
  logic [4:0]           q_reg_d  [DEPTH];
  logic [31:0]          q_data_q [DEPTH];
  logic [31:0]          q_data_d [DEPTH];
  logic                 q_link_q [DEPTH];
  logic                 q_link_d [DEPTH];
  logic                 srw_q, srw_d, jal_q, jal_d;
  logic [4:0]           wreg_q, wreg_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [JAL_WIDTH-1:0] jaddr_q, jaddr_d;

  logic       full, push, push_keep, pop;
  logic       haz1, haz2;
  logic [PW-1:0] idx;
  logic [4:0] tgt;

  assign full        = (occ_q == OW'(DEPTH));
  assign wb.wb_ready = rst_n && !full && !flush;
  assign push        = wb.wb_valid && wb.wb_ready;
  // Writes to $zero complete the handshake but never occupy a slot.
  assign push_keep   = push && (wb.wb_is_link || (wb.wb_reg != 5'd0));
  assign pop         = drain_enable && (occ_q != '0) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    q_reg_d  = q_reg_q;
    q_data_d = q_data_q;
    q_link_d = q_link_q;
    srw_d    = 1'b0;
    jal_d    = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    jaddr_d  = jaddr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_keep) begin
        q_reg_d[wr_ptr_q]  = wb.wb_reg;
        q_data_d[wr_ptr_q] = wb.wb_data;
        q_link_d[wr_ptr_q] = wb.wb_is_link;
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (q_link_q[rd_ptr_q]) begin
          jal_d   = 1'b1;
          wreg_d  = 5'd0;
          jaddr_d = q_data_q[rd_ptr_q][JAL_WIDTH-1:0];
        end else begin
          srw_d   = 1'b1;
          wreg_d  = q_reg_q[rd_ptr_q];
          wdata_d = q_data_q[rd_ptr_q];
        end
      end
      case ({push_keep, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_reg_q[i]  <= '0;
        q_data_q[i] <= '0;
        q_link_q[i] <= 1'b0;
      end
      srw_q   <= 1'b0;
      jal_q   <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      jaddr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      q_reg_q  <= q_reg_d;
      q_data_q <= q_data_d;
      q_link_q <= q_link_d;
      srw_q    <= srw_d;
      jal_q    <= jal_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      jaddr_q  <= jaddr_d;
    end
  end

  // A link entry is a pending write to $ra (r31).
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    idx  = '0;
    tgt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      tgt = q_link_q[idx] ? 5'd31 : q_reg_q[idx];
      if (OW'(i) < occ_q) begin
        if (tgt == read_reg_1) haz1 = 1'b1;
        if (tgt == read_reg_2) haz2 = 1'b1;
      end
    end
    if ((srw_q && wreg_q == read_reg_1) || (jal_q && read_reg_1 == 5'd31)) haz1 = 1'b1;
    if ((srw_q && wreg_q == read_reg_2) || (jal_q && read_reg_2 == 5'd31)) haz2 = 1'b1;
  end

  assign hazard_1         = haz1 && (read_reg_1 != 5'd0);
  assign hazard_2         = haz2 && (read_reg_2 != 5'd0);
  assign write_reg        = wreg_q;
  assign write_data       = wdata_q;
  assign signal_reg_write = srw_q;
  assign jal              = jal_q;
  assign jal_address      = jaddr_q;
  assign occupancy        = occ_q;

endmodule

// File: tb/tb_mips_reg_writeback.sv
// Directed table-driven bench for mips_reg_writeback plus hand-written reset-mid-drain sequence.
module tb_mips_reg_writeback;

  typedef struct packed {
    logic        v;
    logic [4:0]  rg;
    logic [31:0] d;
    logic        lk, dr, fl;
    logic [4:0]  r1, r2;
  } in_t;

  typedef struct packed {
    logic        rdy, srw, jl;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [12:0] ja;
    logic [2:0]  occ;
    logic        h1, h2;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  localparam int NV = 31;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drain_enable, flush;
  logic [4:0]  read_reg_1, read_reg_2;
  logic        hazard_1, hazard_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        signal_reg_write, jal;
  logic [12:0] jal_address;
  logic [2:0]  occupancy;

  int n_pass  = 0;
  int n_total = 0;
  vec_t tbl [NV];

  mips_reg_writeback_if ifc ();

  mips_reg_writeback #(.DEPTH(4), .JAL_WIDTH(13)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb               (ifc),
    .drain_enable     (drain_enable),
    .flush            (flush),
    .read_reg_1       (read_reg_1),
    .read_reg_2       (read_reg_2),
    .hazard_1         (hazard_1),
    .hazard_2         (hazard_2),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .signal_reg_write (signal_reg_write),
    .jal              (jal),
    .jal_address      (jal_address),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  function automatic in_t mi(input logic v, input logic [4:0] rg, input logic [31:0] d,
                             input logic lk, input logic dr, input logic fl,
                             input logic [4:0] r1, input logic [4:0] r2);
    mi = '{v, rg, d, lk, dr, fl, r1, r2};
  endfunction

  function automatic out_t mo(input logic rdy, input logic srw, input logic jl,
                              input logic [4:0] wreg, input logic [31:0] wdata,
                              input logic [12:0] ja, input logic [2:0] occ,
                              input logic h1, input logic h2);
    mo = '{rdy, srw, jl, wreg, wdata, ja, occ, h1, h2};
  endfunction

  task automatic drive(input in_t x);
    ifc.wb_valid   = x.v;
    ifc.wb_reg     = x.rg;
    ifc.wb_data    = x.d;
    ifc.wb_is_link = x.lk;
    drain_enable   = x.dr;
    flush          = x.fl;
    read_reg_1     = x.r1;
    read_reg_2     = x.r2;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = '{ifc.wb_ready, signal_reg_write, jal, write_reg, write_data,
            jal_address, occupancy, hazard_1, hazard_2};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got rdy=%b srw=%b jal=%b wreg=%0d wdata=%h ja=%h occ=%0d h1=%b h2=%b, expected rdy=%b srw=%b jal=%b wreg=%0d wdata=%h ja=%h occ=%0d h1=%b h2=%b",
                  name, act.rdy, act.srw, act.jl, act.wreg, act.wdata, act.ja, act.occ, act.h1, act.h2,
                  exp.rdy, exp.srw, exp.jl, exp.wreg, exp.wdata, exp.ja, exp.occ, exp.h1, exp.h2);
  endtask

  initial begin
    // Basic write of r5
    tbl[0]  = '{mi(1, 5, 32'hDEADBEEF, 0, 1, 0, 5, 0),  mo(1, 0, 0, 0, 32'h0,        13'h0,  0, 0, 0)};
    tbl[1]  = '{mi(0, 0, 32'h0,        0, 1, 0, 5, 0),  mo(1, 0, 0, 0, 32'h0,        13'h0,  1, 1, 0)};
    tbl[2]  = '{mi(0, 0, 32'h0,        0, 1, 0, 5, 0),  mo(1, 1, 0, 5, 32'hDEADBEEF, 13'h0,  0, 1, 0)};
    tbl[3]  = '{mi(0, 0, 32'h0,        0, 1, 0, 5, 0),  mo(1, 0, 0, 5, 32'hDEADBEEF, 13'h0,  0, 0, 0)};
    // Link entry; wb_reg=7 must be ignored
    tbl[4]  = '{mi(1, 7, 32'h40,       1, 1, 0, 31, 7), mo(1, 0, 0, 5, 32'hDEADBEEF, 13'h0,  0, 0, 0)};
    tbl[5]  = '{mi(0, 0, 32'h0,        0, 1, 0, 31, 7), mo(1, 0, 0, 5, 32'hDEADBEEF, 13'h0,  1, 1, 0)};
    tbl[6]  = '{mi(0, 0, 32'h0,        0, 1, 0, 31, 7), mo(1, 0, 1, 0, 32'hDEADBEEF, 13'h40, 0, 1, 0)};
    tbl[7]  = '{mi(0, 0, 32'h0,        0, 1, 0, 31, 7), mo(1, 0, 0, 0, 32'hDEADBEEF, 13'h40, 0, 0, 0)};
    // Fill to full with drain off, fifth push refused
    tbl[8]  = '{mi(1, 1, 32'h11,       0, 0, 0, 3, 5),  mo(1, 0, 0, 0, 32'hDEADBEEF, 13'h40, 0, 0, 0)};
    tbl[9]  = '{mi(1, 2, 32'h22,       0, 0, 0, 3, 5),  mo(1, 0, 0, 0, 32'hDEADBEEF, 13'h40, 1, 0, 0)};
    tbl[10] = '{mi(1, 3, 32'h33,       0, 0, 0, 3, 5),  mo(1, 0, 0, 0, 32'hDEADBEEF, 13'h40, 2, 0, 0)};
    tbl[11] = '{mi(1, 4, 32'h44,       0, 0, 0, 3, 5),  mo(1, 0, 0, 0, 32'hDEADBEEF, 13'h40, 3, 1, 0)};
    tbl[12] = '{mi(1, 5, 32'h55,       0, 0, 0, 3, 5),  mo(0, 0, 0, 0, 32'hDEADBEEF, 13'h40, 4, 1, 0)};
    tbl[13] = '{mi(0, 0, 32'h0,        0, 1, 0, 3, 5),  mo(0, 0, 0, 0, 32'hDEADBEEF, 13'h40, 4, 1, 0)};
    tbl[14] = '{mi(0, 0, 32'h0,        0, 1, 0, 3, 5),  mo(1, 1, 0, 1, 32'h11,       13'h40, 3, 1, 0)};
    tbl[15] = '{mi(0, 0, 32'h0,        0, 1, 0, 3, 5),  mo(1, 1, 0, 2, 32'h22,       13'h40, 2, 1, 0)};
    tbl[16] = '{mi(0, 0, 32'h0,        0, 1, 0, 3, 5),  mo(1, 1, 0, 3, 32'h33,       13'h40, 1, 1, 0)};
    tbl[17] = '{mi(0, 0, 32'h0,        0, 1, 0, 3, 5),  mo(1, 1, 0, 4, 32'h44,       13'h40, 0, 0, 0)};
    tbl[18] = '{mi(0, 0, 32'h0,        0, 1, 0, 3, 5),  mo(1, 0, 0, 4, 32'h44,       13'h40, 0, 0, 0)};
    // Push to r0 is swallowed
    tbl[19] = '{mi(1, 0, 32'h99,       0, 1, 0, 0, 0),  mo(1, 0, 0, 4, 32'h44,       13'h40, 0, 0, 0)};
    tbl[20] = '{mi(0, 0, 32'h0,        0, 1, 0, 0, 0),  mo(1, 0, 0, 4, 32'h44,       13'h40, 0, 0, 0)};
    tbl[21] = '{mi(0, 0, 32'h0,        0, 1, 0, 0, 0),  mo(1, 0, 0, 4, 32'h44,       13'h40, 0, 0, 0)};
    // Two queued, then push and pop together
    tbl[22] = '{mi(1, 10, 32'hA0,      0, 0, 0, 10, 11), mo(1, 0, 0, 4, 32'h44,      13'h40, 0, 0, 0)};
    tbl[23] = '{mi(1, 11, 32'hB0,      0, 0, 0, 10, 11), mo(1, 0, 0, 4, 32'h44,      13'h40, 1, 1, 0)};
    tbl[24] = '{mi(1, 12, 32'hC0,      0, 1, 0, 10, 11), mo(1, 0, 0, 4, 32'h44,      13'h40, 2, 1, 1)};
    tbl[25] = '{mi(0, 0, 32'h0,        0, 0, 0, 10, 12), mo(1, 1, 0, 10, 32'hA0,     13'h40, 2, 1, 1)};
    tbl[26] = '{mi(0, 0, 32'h0,        0, 0, 0, 10, 12), mo(1, 0, 0, 10, 32'hA0,     13'h40, 2, 0, 1)};
    // Three queued, flush with an offered entry
    tbl[27] = '{mi(1, 13, 32'hD0,      0, 0, 0, 13, 11), mo(1, 0, 0, 10, 32'hA0,     13'h40, 2, 0, 1)};
    tbl[28] = '{mi(1, 14, 32'hE0,      0, 1, 1, 14, 11), mo(0, 0, 0, 10, 32'hA0,     13'h40, 3, 0, 1)};
    tbl[29] = '{mi(0, 0, 32'h0,        0, 1, 0, 14, 11), mo(1, 0, 0, 10, 32'hA0,     13'h40, 0, 0, 0)};
    tbl[30] = '{mi(0, 0, 32'h0,        0, 1, 0, 14, 11), mo(1, 0, 0, 10, 32'hA0,     13'h40, 0, 0, 0)};

    rst_n = 1'b0;
    drive(mi(0, 0, 32'h0, 0, 0, 0, 0, 0));
    #3;
    check("reset_state", mo(0, 0, 0, 0, 32'h0, 13'h0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_reset", mo(1, 0, 0, 0, 32'h0, 13'h0, 0, 0, 0));

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(tbl[k].i);
      #1;
      check($sformatf("vec%0d", k), tbl[k].e);
    end

    // Reset asserted while a strobe is on the output and one entry remains queued
    @(negedge clk);
    drive(mi(1, 20, 32'h200, 0, 0, 0, 21, 20));
    @(negedge clk);
    drive(mi(1, 21, 32'h210, 0, 0, 0, 21, 20));
    @(negedge clk);
    drive(mi(0, 0, 32'h0, 0, 1, 0, 21, 20));
    @(negedge clk);
    #1;
    check("pre_reset_drain", mo(1, 1, 0, 20, 32'h200, 13'h40, 1, 1, 1));
    rst_n = 1'b0;
    #1;
    check("reset_mid_drain", mo(0, 0, 0, 0, 32'h0, 13'h0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", mo(1, 0, 0, 0, 32'h0, 13'h0, 0, 0, 0));
    @(negedge clk);
    #1;
    check("no_drain_after_reset", mo(1, 0, 0, 0, 32'h0, 13'h0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_reg_writeback.md
# mips_reg_writeback

Write-back initiator for the 32x32 MIPS register file: buffers completed results (ALU, load, JAL link) in a small in-order queue and drains at most one per clock onto the register file's write port (`write_reg`/`write_data`/`signal_reg_write`) or its link port (`jal`/`jal_address`). Also acts as a scoreboard, flagging decode-stage source registers that still have a pending write. Sits between the execute/memory stages and the register file, which commits on the falling edge of `clk`.

## Interface
- `DEPTH`, 4, queue entries; power of two, at least 2
- `JAL_WIDTH`, 13, width of the link address driven to the register file
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wb_valid`  in  1  producer offers an entry
- `wb_ready`  out  1  queue can accept; `!full && !flush && rst_n`
- `wb_reg`  in  5  destination register
- `wb_data`  in  32  result value, or link address in `[JAL_WIDTH-1:0]`
- `wb_is_link`  in  1  entry is a JAL link (`wb_reg` ignored)
- `drain_enable`  in  1  permits issuing one entry this cycle
- `flush`  in  1  synchronous discard of all pending entries
- `read_reg_1`, `read_reg_2`  in  5 each  decode-stage source registers
- `hazard_1`, `hazard_2`  out  1 each  matching source has a pending write
- `write_reg`  out  5  to register file
- `write_data`  out  32  to register file
- `signal_reg_write`  out  1  one-cycle write strobe
- `jal`  out  1  one-cycle link strobe
- `jal_address`  out  JAL_WIDTH  link value
- `occupancy`  out  $clog2(DEPTH+1)  queued entries, excluding the output register

## Operation
- **Push.**
  - A push happens when `wb_valid && wb_ready` at a rising edge.
  - An entry with `wb_reg==0 && !wb_is_link` completes the handshake but is discarded; occupancy is unchanged.
- **Pop.**
  - At each edge, if `drain_enable && occupancy>0 && !flush`, the head entry is loaded into the output register.
  - Normal entry: `signal_reg_write=1`, `jal=0`, `write_reg=entry.reg`, `write_data=entry.data`.
  - Link entry: `jal=1`, `signal_reg_write=0`, `jal_address=entry.data[JAL_WIDTH-1:0]` passed unchanged (the register file applies its own -1), `write_reg=0`.
  - Otherwise both strobes go to 0 and data/address outputs hold their last values.
- **Ordering.** Strict FIFO; link and normal entries are never reordered.
- **Simultaneous push and pop.** Both take effect; occupancy is unchanged. A push into an empty queue is not bypassed.
- **Full.** `wb_ready=0` when occupancy==DEPTH, even if a pop occurs in the same cycle.
- **Flush.**
  - At the edge, read and write pointers and occupancy go to 0 and both strobes go to 0.
  - Any push that cycle is blocked (`wb_ready=0`).
  - Flush has priority over push and pop.
- **Hazards.** Combinational. `hazard_n=1` iff `read_reg_n!=0` and either of these holds:
  - a queued entry targets it (a link entry counts as register 31);
  - the output register holds an entry with its strobe high that targets it.
- **Pointers.** Wrap modulo DEPTH.

## Timing
- **Reset (`rst_n` low, asynchronous).**
  - Occupancy, pointers, `signal_reg_write`, `jal`, `write_reg`, `write_data` and `jal_address` are all 0.
  - `hazard_1`, `hazard_2` and `wb_ready` are 0.
  - After deassertion: `wb_ready=1`; hazards 0.
  - Reset mid-drain drops all pending entries and any strobe immediately.
- **Latency.**
  - An entry accepted at edge N with `drain_enable` high and an empty queue strobes from edge N+1 to edge N+2.
  - The register file commits it at the falling edge inside that window.
- **Throughput.** One write or one link per cycle; `signal_reg_write` and `jal` are never high together.
- **Hazard timing.**
  - `hazard_n` rises in the cycle after acceptance, as a combinational function of the registered state.
  - It falls after the strobe cycle ends, unless another pending entry matches.

## Test plan
- **Basic write.**
  - Stimulus: reset, then push (reg 5, 0xDEADBEEF) with `drain_enable=1`.
  - Required: one cycle later `signal_reg_write=1`, `write_reg=5`, `write_data=0xDEADBEEF` for exactly one cycle.
  - Required: `hazard_1=1` for `read_reg_1=5` during those two cycles, 0 afterwards.
- **Link.**
  - Stimulus: push `wb_is_link` with data 0x0040.
  - Required: `jal=1`, `jal_address=0x0040`, `signal_reg_write=0`.
  - Required: `hazard` on `read_reg=31` until the strobe cycle ends.
- **Full/backpressure.**
  - Stimulus: `drain_enable=0`, then push 5 entries for regs 1..5.
  - Required: the 5th sees `wb_ready=0`; `occupancy=4`.
  - Stimulus: then raise `drain_enable`.
  - Required: strobes for regs 1,2,3,4 in order on consecutive cycles; reg 5 is never written unless re-offered.
- **Register 0 and simultaneous push/pop.**
  - Stimulus: push reg 0.
  - Required: handshake completes, no strobe, `occupancy=0`, `hazard` for reg 0 stays 0.
  - Stimulus: with 2 entries queued, push and pop in the same cycle.
  - Required: occupancy stays 2.
- **Flush and reset mid-operation.**
  - Stimulus: with 3 entries queued, assert `flush` while `wb_valid=1`.
  - Required: next cycle `occupancy=0`, no strobes, hazards 0, and the offered entry is not accepted.
  - Stimulus: repeat with `rst_n` pulsed low mid-drain.
  - Required: all outputs 0 immediately.
